// File: rtl/bcd_counter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_counter_pkg: BCD digit constants shared with display.        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package bcd_counter_pkg;

  localparam int             BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int             DIGITS  = 2;
  localparam int             DATA_W  = BCD_W * DIGITS;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // True when every nibble of a packed BCD word is a legal decimal digit.
  function automatic logic bcd_is_valid(input logic [DATA_W-1:0] value);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (value[i*BCD_W +: BCD_W] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tick_gen: free-running prescaler, tick on the last count value.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tick_gen #(
  parameter int PRESCALE   = 100_000_000,
  parameter int PRESCALE_W = 27
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;

  assign tick = (count_q == PRESCALE_W'(PRESCALE - 1));

  always_comb begin
    count_d = count_q;
    if (!enable || clear || tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_counter: two-digit BCD up/down counter with load and carry.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module bcd_counter
  import bcd_counter_pkg::*;
#(
  parameter int PRESCALE   = 100_000_000,
  parameter int PRESCALE_W = 27
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              up_down,
  input  logic              step,
  input  logic              load,
  input  logic [DATA_W-1:0] load_value,
  output logic [DATA_W-1:0] DATA,
  output logic              carry,
  output logic              load_err
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              carry_q, carry_d;
  logic              load_err_q, load_err_d;
  logic              step_d_q, step_d_d;
  logic              armed_q, armed_d;

  logic       tick;
  logic       step_rise;
  logic       ev;
  logic       load_ok;
  logic       chain;
  logic       wrap;
  bcd_digit_t digit;

  assign load_ok = bcd_is_valid(load_value);

  tick_gen #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .clear  (load & load_ok),
    .tick   (tick)
  );

  // armed_q blocks a step that was already high during reset until it drops.
  assign step_rise = step & ~step_d_q & armed_q;
  assign ev        = (enable & tick) | step_rise;
  assign step_d_d  = step;
  assign armed_d   = armed_q | ~step;

  always_comb begin
    data_d     = data_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    chain      = 1'b1;
    wrap       = 1'b0;
    digit      = '0;
    if (load) begin
      if (load_ok) begin
        data_d = load_value;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (ev) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit = data_q[i*BCD_W +: BCD_W];
        if (chain) begin
          if (up_down) begin
            wrap = (digit == BCD_MAX);
            data_d[i*BCD_W +: BCD_W] = wrap ? '0 : digit + BCD_W'(1);
          end else begin
            wrap = (digit == '0);
            data_d[i*BCD_W +: BCD_W] = wrap ? BCD_MAX : digit - BCD_W'(1);
          end
          chain = wrap;
        end
      end
      carry_d = chain;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q     <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
      step_d_q   <= 1'b0;
      armed_q    <= ~step;
    end else begin
      data_q     <= data_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
      step_d_q   <= step_d_d;
      armed_q    <= armed_d;
    end
  end

  assign DATA     = data_q;
  assign carry    = carry_q;
  assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bcd_counter: directed plus random stimulus vs decimal model.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_bcd_counter;

  localparam int P = 4;

  logic       clock = 1'b0;
  logic       reset, enable, up_down, step, load;
  logic [7:0] load_value;
  logic [7:0] DATA;
  logic       carry, load_err;

  int checks = 0;
  int errors = 0;

  int m_data;
  int m_cnt;
  bit m_prev;
  bit m_carry;
  bit m_err;

  bcd_counter #(.PRESCALE(P), .PRESCALE_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .step       (step),
    .load       (load),
    .load_value (load_value),
    .DATA       (DATA),
    .carry      (carry),
    .load_err   (load_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Decimal reference: count held as 0..99, prescaler as a plain integer.
  task automatic model_edge();
    int  t, u;
    bit  tk, rise, valid;
    if (reset) begin
      m_data = 0; m_carry = 0; m_err = 0; m_cnt = 0;
      m_prev = step;
      return;
    end
    tk     = enable && (m_cnt == P - 1);
    rise   = step && !m_prev;
    m_prev = step;
    t      = int'(load_value[7:4]);
    u      = int'(load_value[3:0]);
    valid  = (t <= 9) && (u <= 9);
    m_carry = 0;
    m_err   = 0;
    if (load) begin
      if (valid) m_data = t * 10 + u;
      else       m_err  = 1;
    end else if (tk || rise) begin
      if (up_down) begin
        m_carry = (m_data == 99);
        m_data  = (m_data + 1) % 100;
      end else begin
        m_carry = (m_data == 0);
        m_data  = (m_data + 99) % 100;
      end
    end
    if (!enable || (load && valid) || m_cnt == P - 1) m_cnt = 0;
    else                                             m_cnt = m_cnt + 1;
  endtask

  task automatic clk_cycle();
    @(posedge clock);
    model_edge();
    #1;
    check("data",     32'(DATA),     32'(to_bcd(m_data)));
    check("carry",    32'(carry),    32'(m_carry));
    check("load_err", 32'(load_err), 32'(m_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_cycle();
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_value = v;
    clk_cycle();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up_down = 1'b0; step = 1'b0;
    load = 1'b0; load_value = 8'h00;
    run(2);
    check("reset_data", 32'(DATA), 32'h00);

    // Automatic counting: one increment every P edges.
    reset = 1'b0; enable = 1'b1; up_down = 1'b1;
    run(40);
    check("auto_40", 32'(DATA), 32'h10);

    // Wrap up and down through manual steps.
    enable = 1'b0;
    do_load(8'h98);
    step = 1'b1; clk_cycle(); check("step_99", 32'(DATA), 32'h99);
    step = 1'b0; clk_cycle();
    step = 1'b1; clk_cycle(); check("wrap_up_carry", 32'(carry), 32'h1);
    step = 1'b0; up_down = 1'b0; clk_cycle();
    step = 1'b1; clk_cycle(); check("wrap_dn", 32'(DATA), 32'h99);
    step = 1'b0; clk_cycle();

    do_load(8'h10);
    step = 1'b1; clk_cycle(); check("borrow", 32'(DATA), 32'h09);
    step = 1'b0; clk_cycle();

    // Rejected loads leave the count alone.
    do_load(8'h25);
    do_load(8'h3A); check("bad_lo_err", 32'(load_err), 32'h1);
    clk_cycle();    check("bad_lo_data", 32'(DATA), 32'h25);
    do_load(8'hA3); check("bad_hi_err", 32'(load_err), 32'h1);

    // Coincident tick and step produce a single count.
    up_down = 1'b1; enable = 1'b1;
    do_load(8'h07);
    run(3);
    step = 1'b1; clk_cycle(); check("coincident", 32'(DATA), 32'h08);
    enable = 1'b0; step = 1'b0; clk_cycle();
    step = 1'b1; run(10); check("held_step", 32'(DATA), 32'h09);
    step = 1'b0;

    // Reset with a tick pending.
    enable = 1'b1;
    do_load(8'h57);
    run(3);
    reset = 1'b1; clk_cycle(); check("reset_mid", 32'(DATA), 32'h00);
    reset = 1'b0;
    run(3); check("post_rst_3", 32'(DATA), 32'h00);
    clk_cycle(); check("post_rst_4", 32'(DATA), 32'h01);

    // Held-high step across reset must not count.
    enable = 1'b0; step = 1'b1; reset = 1'b1; clk_cycle();
    reset = 1'b0; run(3); check("step_thru_rst", 32'(DATA), 32'h00);
    step = 1'b0; clk_cycle();
    step = 1'b1; clk_cycle(); check("step_rearmed", 32'(DATA), 32'h01);

    // Random phase.
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      up_down    = 1'($urandom_range(0, 1));
      step       = ($urandom_range(0, 2) == 0) ? ~step : step;
      load       = ($urandom_range(0, 15) == 0);
      load_value = ($urandom_range(0, 1) == 1) ? to_bcd(int'($urandom_range(0, 99)))
                                               : 8'($urandom);
      clk_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
